// File: rtl/i2c_pkg.sv
// Shared I2C master definitions: bit-controller command encodings and byte FSM states.
// Used by i2c_mst_ctrl_byte and i2c_mst_ctrl_bit.
package i2c_pkg;

   localparam int unsigned BIT_CMD_W = 4;

   localparam logic [BIT_CMD_W-1:0] I2C_CMD_NOP   = 4'b0000;
   localparam logic [BIT_CMD_W-1:0] I2C_CMD_START = 4'b0001;
   localparam logic [BIT_CMD_W-1:0] I2C_CMD_STOP  = 4'b0010;
   localparam logic [BIT_CMD_W-1:0] I2C_CMD_WRITE = 4'b0100;
   localparam logic [BIT_CMD_W-1:0] I2C_CMD_READ  = 4'b1000;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_WRITE = 3'd2,
      ST_READ  = 3'd3,
      ST_ACK   = 3'd4,
      ST_STOP  = 3'd5
   } byte_state_e;

   // First bit command issued when a byte command enters the given state
   function automatic logic [BIT_CMD_W-1:0] entry_cmd(input byte_state_e s);
      logic [BIT_CMD_W-1:0] c;
      c = I2C_CMD_NOP;
      case (s)
         ST_START: c = I2C_CMD_START;
         ST_WRITE: c = I2C_CMD_WRITE;
         ST_READ:  c = I2C_CMD_READ;
         ST_STOP:  c = I2C_CMD_STOP;
         default:  c = I2C_CMD_NOP;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/i2c_mst_byte_wdog.sv
// Bit-command acknowledge watchdog for the byte sequencer.
// Only built when I2C_MST_BYTE_TIMEOUT_EN is defined.
`ifdef I2C_MST_BYTE_TIMEOUT_EN
module i2c_mst_byte_wdog #(
   parameter int unsigned TIMEOUT = 65535
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic busy_i,
   output logic hit_c
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] cnt_q;
   logic [TW-1:0] cnt_d;

   // Fires on the cycle whose edge would make the count reach TIMEOUT
   assign hit_c = busy_i & ~clr_i & (cnt_q == TW'(TIMEOUT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (busy_i && !hit_c) begin
         cnt_d = cnt_q + TW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`endif

// File: rtl/i2c_mst_ctrl_byte.sv
// I2C master byte sequencer: splits START/WRITE/READ/ACK/STOP byte commands into bit commands.
// Optional bit-ack watchdog enabled by defining I2C_MST_BYTE_TIMEOUT_EN.
module i2c_mst_ctrl_byte
   import i2c_pkg::*;
#(
   parameter int unsigned DW      = 8,
   parameter int unsigned TIMEOUT = 65535
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ena,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 read,
   input  logic                 write,
   input  logic                 ack_in,
   input  logic [DW-1:0]        din,
   output logic                 cmd_ack,
   output logic                 ack_out,
   output logic [DW-1:0]        dout,
   output logic                 i2c_al,
   output logic                 busy,
   output logic                 timeout,
   output logic [BIT_CMD_W-1:0] bit_cmd,
   output logic                 bit_din,
   input  logic                 bit_cmd_ack,
   input  logic                 bit_al,
   input  logic                 bit_dout
);

   localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

   byte_state_e          state_q;
   logic [DW-1:0]        sr_q;
   logic [DW-1:0]        dout_q;
   logic [CW-1:0]        cnt_q;
   logic                 issue_q;
   logic                 rd_q;
   logic                 busy_q;
   logic [BIT_CMD_W-1:0] bit_cmd_q;
   logic                 bit_din_q;
   logic                 cmd_ack_q;
   logic                 ack_out_q;
   logic                 i2c_al_q;
   logic                 timeout_q;
   logic                 go_c;
   logic                 to_hit_c;

   // A request is ignored in the cmd_ack cycle while the host drops it
   assign go_c = ena & (start | stop | read | write) & ~cmd_ack_q;

`ifdef I2C_MST_BYTE_TIMEOUT_EN
   logic wdog_clr_c;

   assign wdog_clr_c = (bit_cmd_q == I2C_CMD_NOP) | bit_cmd_ack;

   i2c_mst_byte_wdog #(
      .TIMEOUT(TIMEOUT)
   ) u_wdog (
      .clk   (clk),
      .rst   (rst),
      .clr_i (wdog_clr_c),
      .busy_i(busy_q),
      .hit_c (to_hit_c)
   );
`else
   logic unused_timeout_c;

   assign unused_timeout_c = |32'(TIMEOUT);
   assign to_hit_c         = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         sr_q      <= '0;
         dout_q    <= '0;
         cnt_q     <= '0;
         issue_q   <= 1'b0;
         rd_q      <= 1'b0;
         busy_q    <= 1'b0;
         bit_cmd_q <= I2C_CMD_NOP;
         bit_din_q <= 1'b0;
         cmd_ack_q <= 1'b0;
         ack_out_q <= 1'b0;
         i2c_al_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         cmd_ack_q <= 1'b0;
         i2c_al_q  <= 1'b0;
         timeout_q <= 1'b0;

         if (bit_al) begin
            // Arbitration loss wins over everything, including a same-cycle ack
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            issue_q   <= 1'b0;
            bit_cmd_q <= I2C_CMD_NOP;
            i2c_al_q  <= 1'b1;
         end else if (to_hit_c) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            issue_q   <= 1'b0;
            bit_cmd_q <= I2C_CMD_NOP;
            timeout_q <= 1'b1;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (go_c) begin
                     sr_q    <= din;
                     cnt_q   <= CW'(DW - 1);
                     issue_q <= 1'b1;
                     busy_q  <= 1'b1;
                     rd_q    <= ~start & ~write & read;
                     if (start)      state_q <= ST_START;
                     else if (write) state_q <= ST_WRITE;
                     else if (read)  state_q <= ST_READ;
                     else            state_q <= ST_STOP;
                  end
               end

               default: begin
                  if (issue_q) begin
                     // First bit command goes out one cycle after acceptance
                     issue_q   <= 1'b0;
                     bit_cmd_q <= entry_cmd(state_q);
                     bit_din_q <= sr_q[DW-1];
                  end else if (bit_cmd_ack) begin
                     case (state_q)
                        ST_START: begin
                           if (write) begin
                              state_q   <= ST_WRITE;
                              bit_cmd_q <= I2C_CMD_WRITE;
                              bit_din_q <= sr_q[DW-1];
                           end else if (read) begin
                              state_q   <= ST_READ;
                              rd_q      <= 1'b1;
                              bit_cmd_q <= I2C_CMD_READ;
                           end else if (stop) begin
                              state_q   <= ST_STOP;
                              bit_cmd_q <= I2C_CMD_STOP;
                           end else begin
                              state_q   <= ST_IDLE;
                              busy_q    <= 1'b0;
                              bit_cmd_q <= I2C_CMD_NOP;
                              cmd_ack_q <= 1'b1;
                           end
                        end

                        ST_WRITE, ST_READ: begin
                           sr_q  <= {sr_q[DW-2:0], bit_dout};
                           cnt_q <= cnt_q - CW'(1);
                           if (cnt_q == '0) begin
                              state_q <= ST_ACK;
                              if (rd_q) begin
                                 bit_cmd_q <= I2C_CMD_WRITE;
                                 bit_din_q <= ack_in;
                              end else begin
                                 bit_cmd_q <= I2C_CMD_READ;
                              end
                           end else begin
                              bit_din_q <= sr_q[DW-2];
                           end
                        end

                        ST_ACK: begin
                           if (rd_q) dout_q    <= sr_q;
                           else      ack_out_q <= bit_dout;
                           if (stop) begin
                              state_q   <= ST_STOP;
                              bit_cmd_q <= I2C_CMD_STOP;
                           end else begin
                              state_q   <= ST_IDLE;
                              busy_q    <= 1'b0;
                              bit_cmd_q <= I2C_CMD_NOP;
                              cmd_ack_q <= 1'b1;
                           end
                        end

                        default: begin
                           state_q   <= ST_IDLE;
                           busy_q    <= 1'b0;
                           bit_cmd_q <= I2C_CMD_NOP;
                           cmd_ack_q <= 1'b1;
                        end
                     endcase
                  end
               end
            endcase
         end
      end
   end

   assign cmd_ack = cmd_ack_q;
   assign ack_out = ack_out_q;
   assign dout    = dout_q;
   assign i2c_al  = i2c_al_q;
   assign busy    = busy_q;
   assign timeout = timeout_q;
   assign bit_cmd = bit_cmd_q;
   assign bit_din = bit_din_q;

endmodule

// File: tb/tb_i2c_mst_ctrl_byte.sv
// Directed self-checking bench for i2c_mst_ctrl_byte with a behavioural bit-controller responder.
// Adds a watchdog test when I2C_MST_BYTE_TIMEOUT_EN is defined.
module tb_i2c_mst_ctrl_byte;
   import i2c_pkg::*;

   localparam int unsigned DW = 8;
`ifdef I2C_MST_BYTE_TIMEOUT_EN
   localparam int unsigned TB_TIMEOUT = 32;
`else
   localparam int unsigned TB_TIMEOUT = 65535;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          ena = 1'b1;
   logic          start = 1'b0, stop = 1'b0, read = 1'b0, write = 1'b0;
   logic          ack_in = 1'b0;
   logic [DW-1:0] din = '0;
   logic          cmd_ack, ack_out, i2c_al, busy, timeout, bit_din;
   logic [DW-1:0] dout;
   logic [3:0]    bit_cmd;
   logic          bit_cmd_ack = 1'b0, bit_al = 1'b0, bit_dout = 1'b0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int n_cmd_ack = 0, n_al = 0, n_to = 0;

   logic       model_en = 1'b1;
   int         al_at = 0;
   logic       rd_bits[$];
   logic [3:0] log_cmd[$];
   logic       log_din[$];
   int         last_ack_cyc = 0;

   int got_ack, got_al, got_to, req_cyc, first_cyc, done_cyc;
   logic [3:0] done_bit_cmd;
   logic       done_busy;

   i2c_mst_ctrl_byte #(
      .DW     (DW),
      .TIMEOUT(TB_TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ena        (ena),
      .start      (start),
      .stop       (stop),
      .read       (read),
      .write      (write),
      .ack_in     (ack_in),
      .din        (din),
      .cmd_ack    (cmd_ack),
      .ack_out    (ack_out),
      .dout       (dout),
      .i2c_al     (i2c_al),
      .busy       (busy),
      .timeout    (timeout),
      .bit_cmd    (bit_cmd),
      .bit_din    (bit_din),
      .bit_cmd_ack(bit_cmd_ack),
      .bit_al     (bit_al),
      .bit_dout   (bit_dout)
   );

   initial forever #5 clk = ~clk;
   initial forever begin @(posedge clk); cyc++; end

   initial forever begin
      @(negedge clk);
      if (cmd_ack) n_cmd_ack++;
      if (i2c_al)  n_al++;
      if (timeout) n_to++;
   end

   initial begin
      #200000;
      $display("FAIL global_time_limit got running exp finished");
      $fatal(1, "time limit");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Bit controller: acks each bit command on its third cycle; READ bits come from rd_bits
   initial begin : bit_model
      int lat;
      lat = 0;
      forever begin
         @(posedge clk); #1;
         bit_cmd_ack = 1'b0;
         bit_al      = 1'b0;
         if (model_en && !rst && bit_cmd != I2C_CMD_NOP) begin
            lat++;
            if (lat == 3) begin
               lat = 0;
               log_cmd.push_back(bit_cmd);
               log_din.push_back(bit_din);
               if (al_at != 0 && log_cmd.size() == al_at) bit_al = 1'b1;
               bit_cmd_ack  = 1'b1;
               last_ack_cyc = cyc;
               if (bit_cmd == I2C_CMD_READ && rd_bits.size() > 0) bit_dout = rd_bits.pop_front();
               else                                              bit_dout = bit_din;
            end
         end else begin
            lat = 0;
         end
      end
   end

   task automatic do_cmd(input logic s, input logic w, input logic r, input logic p,
                         input logic [DW-1:0] d, input logic ai, input logic drop_ena);
      int n;
      got_ack = 0; got_al = 0; got_to = 0; first_cyc = -1; done_cyc = -1;
      log_cmd.delete();
      log_din.delete();
      @(posedge clk); #2;
      start = s; write = w; read = r; stop = p; din = d; ack_in = ai; ena = 1'b1;
      req_cyc = cyc;
      for (n = 0; n < 400; n++) begin
         @(posedge clk); #2;
         if (drop_ena && n == 1) ena = 1'b0;
         if (first_cyc < 0 && bit_cmd != I2C_CMD_NOP) first_cyc = cyc;
         if (cmd_ack || i2c_al || timeout) begin
            got_ack = int'(cmd_ack); got_al = int'(i2c_al); got_to = int'(timeout);
            done_cyc = cyc; done_bit_cmd = bit_cmd; done_busy = busy;
            break;
         end
      end
      start = 1'b0; write = 1'b0; read = 1'b0; stop = 1'b0; ena = 1'b1;
      if (n >= 400) chk("cmd_done_wait", 32'd0, 32'd1);
      @(posedge clk); #2;
   endtask

   initial begin : main
      int n, base_ack, base_al;
      logic [7:0] bits;

      repeat (3) @(posedge clk);
      #2;
      chk("rst_bit_cmd", 32'(bit_cmd), 32'(I2C_CMD_NOP));
      chk("rst_busy", 32'(busy), 0);
      chk("rst_cmd_ack", 32'(cmd_ack), 0);
      chk("rst_dout", 32'(dout), 0);
      chk("rst_ack_out", 32'(ack_out), 0);
      chk("rst_i2c_al", 32'(i2c_al), 0);
      chk("rst_timeout", 32'(timeout), 0);
      chk("rst_bit_din", 32'(bit_din), 0);
      rst = 1'b0;

      // start+write 0xA5, slave ACKs
      base_ack = n_cmd_ack;
      rd_bits.delete(); rd_bits.push_back(1'b0);
      do_cmd(1, 1, 0, 0, 8'hA5, 0, 0);
      chk("t1_first_cmd_lat", 32'(first_cyc - req_cyc), 2);
      chk("t1_len", 32'(log_cmd.size()), 10);
      bits = 8'b1010_0101;
      if (log_cmd.size() == 10) begin
         chk("t1_c0", 32'(log_cmd[0]), 32'(I2C_CMD_START));
         for (int i = 0; i < 8; i++) begin
            chk("t1_wr_cmd", 32'(log_cmd[1+i]), 32'(I2C_CMD_WRITE));
            chk("t1_wr_din", 32'(log_din[1+i]), 32'(bits[7-i]));
         end
         chk("t1_ack_cmd", 32'(log_cmd[9]), 32'(I2C_CMD_READ));
      end
      chk("t1_got_ack", 32'(got_ack), 1);
      chk("t1_ack_lat", 32'(done_cyc - last_ack_cyc), 1);
      chk("t1_ack_out", 32'(ack_out), 0);
      chk("t1_cmd_ack_cnt", 32'(n_cmd_ack - base_ack), 1);
      chk("t1_cmd_ack_pulse", 32'(cmd_ack), 0);
      chk("t1_busy_after", 32'(busy), 0);

      // write 0x5A alone, slave NACKs
      base_ack = n_cmd_ack;
      rd_bits.delete(); rd_bits.push_back(1'b1);
      do_cmd(0, 1, 0, 0, 8'h5A, 0, 0);
      chk("t1b_len", 32'(log_cmd.size()), 9);
      bits = 8'b0101_1010;
      if (log_cmd.size() == 9) begin
         for (int i = 0; i < 8; i++) begin
            chk("t1b_wr_cmd", 32'(log_cmd[i]), 32'(I2C_CMD_WRITE));
            chk("t1b_wr_din", 32'(log_din[i]), 32'(bits[7-i]));
         end
         chk("t1b_ack_cmd", 32'(log_cmd[8]), 32'(I2C_CMD_READ));
      end
      chk("t1b_ack_out", 32'(ack_out), 1);
      chk("t1b_cmd_ack_cnt", 32'(n_cmd_ack - base_ack), 1);

      // read+stop, master NACKs, slave returns 0x3C
      base_ack = n_cmd_ack;
      rd_bits.delete();
      bits = 8'h3C;
      for (int i = 7; i >= 0; i--) rd_bits.push_back(bits[i]);
      do_cmd(0, 0, 1, 1, 8'h00, 1, 0);
      chk("t2_len", 32'(log_cmd.size()), 10);
      if (log_cmd.size() == 10) begin
         for (int i = 0; i < 8; i++) chk("t2_rd_cmd", 32'(log_cmd[i]), 32'(I2C_CMD_READ));
         chk("t2_ack_cmd", 32'(log_cmd[8]), 32'(I2C_CMD_WRITE));
         chk("t2_ack_din", 32'(log_din[8]), 1);
         chk("t2_stop_cmd", 32'(log_cmd[9]), 32'(I2C_CMD_STOP));
      end
      chk("t2_dout", 32'(dout), 32'h3C);
      chk("t2_cmd_ack_cnt", 32'(n_cmd_ack - base_ack), 1);

      // stop alone, ena dropped mid-command
      base_ack = n_cmd_ack;
      do_cmd(0, 0, 0, 1, 8'h00, 0, 1);
      chk("t3_len", 32'(log_cmd.size()), 1);
      if (log_cmd.size() == 1) chk("t3_cmd", 32'(log_cmd[0]), 32'(I2C_CMD_STOP));
      chk("t3_got_ack", 32'(got_ack), 1);
      chk("t3_ack_lat", 32'(done_cyc - last_ack_cyc), 1);
      chk("t3_busy_after", 32'(busy), 0);
      chk("t3_cmd_ack_cnt", 32'(n_cmd_ack - base_ack), 1);

      // arbitration lost on the 4th write bit, coincident with its ack
      base_ack = n_cmd_ack;
      base_al  = n_al;
      al_at = 4;
      do_cmd(0, 1, 0, 0, 8'hF0, 0, 0);
      al_at = 0;
      repeat (5) @(posedge clk);
      #2;
      chk("t4_got_al", 32'(got_al), 1);
      chk("t4_len", 32'(log_cmd.size()), 4);
      chk("t4_bit_cmd", 32'(done_bit_cmd), 32'(I2C_CMD_NOP));
      chk("t4_busy", 32'(done_busy), 0);
      chk("t4_al_cnt", 32'(n_al - base_al), 1);
      chk("t4_no_cmd_ack", 32'(n_cmd_ack - base_ack), 0);

      // reset asserted in the middle of a read
      rd_bits.delete();
      log_cmd.delete(); log_din.delete();
      @(posedge clk); #2;
      read = 1'b1;
      for (n = 0; n < 200 && log_cmd.size() < 3; n++) begin @(posedge clk); #2; end
      chk("t5_reached_mid", 32'(log_cmd.size() >= 3), 1);
      chk("t5_busy_before", 32'(busy), 1);
      read = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk("t5_bit_cmd", 32'(bit_cmd), 32'(I2C_CMD_NOP));
      chk("t5_busy", 32'(busy), 0);
      chk("t5_dout", 32'(dout), 0);
      chk("t5_ack_out", 32'(ack_out), 0);
      chk("t5_cmd_ack", 32'(cmd_ack), 0);
      chk("t5_bit_din", 32'(bit_din), 0);
      @(posedge clk); #2;
      rst = 1'b0;
      base_ack = n_cmd_ack;
      rd_bits.delete(); rd_bits.push_back(1'b0);
      do_cmd(0, 1, 0, 0, 8'h81, 0, 0);
      chk("t5_wr_len", 32'(log_cmd.size()), 9);
      chk("t5_wr_cmd_ack_cnt", 32'(n_cmd_ack - base_ack), 1);

`ifdef I2C_MST_BYTE_TIMEOUT_EN
      // bit ack withheld: watchdog fires
      base_ack = n_cmd_ack;
      model_en = 1'b0;
      do_cmd(0, 0, 0, 1, 8'h00, 0, 0);
      model_en = 1'b1;
      chk("t6_got_to", 32'(got_to), 1);
      chk("t6_to_lat", 32'(done_cyc - first_cyc), 32);
      chk("t6_bit_cmd", 32'(done_bit_cmd), 32'(I2C_CMD_NOP));
      chk("t6_no_cmd_ack", 32'(n_cmd_ack - base_ack), 0);
      chk("t6_to_cnt", 32'(n_to), 1);
`else
      chk("no_timeout_pulse", 32'(n_to), 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
